lcd_sequencer: RTL and testbench
================================

Name: lcd_sequencer

Overview:
Command/character sequencer that drives the lcd_controller write port (rs_in, data_in, strobe_in, period_clk_ns; done handshake). Runs the HD44780 power-up init list, then accepts a byte stream from an upstream requester over a valid/ready handshake. Tracks the cursor on a 2-row display and inserts DDRAM set-address commands on line wrap and newline. Serves clear requests with the mandatory post-clear delay. Sits between application logic (or the VIO in the hardware bench) and lcd_controller.

Parameters:
CLK_PERIOD_NS, 20, clock period in ns; driven unchanged on ctl_period_clk_ns (8 bits, must be <= 255).
POWERUP_CYCLES, 750000, wait after reset before the first command (15 ms at 50 MHz).
CLEAR_WAIT_CYCLES, 82000, extra wait after every 0x01 clear (1.64 ms at 50 MHz).
COLS, 16, characters per row, range 2..16.
TIMEOUT_CYCLES, 65535, done watchdog limit; used only with the optional feature.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
char_valid  in  1  upstream byte valid
char_data  in  8  upstream byte; 0x0A = newline, every other value = character code
char_ready  out  1  sequencer accepts char_data this cycle
clr_req  in  1  single-cycle clear-display request
ctl_rs  out  1  to lcd_controller rs_in (0 = command, 1 = data)
ctl_data  out  8  to lcd_controller data_in
ctl_strobe  out  1  to lcd_controller strobe_in, one-cycle pulse
ctl_period_clk_ns  out  8  to lcd_controller period_clk_ns, constant CLK_PERIOD_NS
ctl_done  in  1  from lcd_controller done, pulse at write completion
init_done  out  1  init list complete, sticky until reset
cursor_col  out  4  current column, 0..COLS-1
cursor_row  out  1  current row
err  out  1  sticky watchdog error (optional feature)

Behaviour:
- Reset (rst=0, asynchronous, overrides any state): FSM=PWRUP, counters=0, ctl_strobe=0, ctl_rs=0, ctl_data=0x00, char_ready=0, init_done=0, cursor_col=0, cursor_row=0, err=0, clear-pending=0. ctl_period_clk_ns is always CLK_PERIOD_NS. Reset in mid-transfer abandons the transfer, and the power-up wait restarts from 0.
- States: PWRUP, ISSUE, WAIT, DELAY, IDLE.
- PWRUP: count POWERUP_CYCLES cycles, then load init index 0 and go to ISSUE.
- Init list (rs=0): 0x28, 0x06, 0x0C, 0x01. After the last entry: init_done=1, col=0, row=0, go to IDLE.
- ISSUE: drive ctl_rs/ctl_data, ctl_strobe=1 for exactly this cycle, then go to WAIT. ctl_rs/ctl_data hold stable until ctl_done is seen.
- WAIT: on ctl_done, go to DELAY if the word was 0x01 with rs=0; otherwise go to the next queued word or to IDLE. ctl_done is ignored in every state except WAIT.
- DELAY: count CLEAR_WAIT_CYCLES cycles, then continue.
- IDLE: char_ready = init_done & ~clear-pending & ~clr_req. A transfer occurs when char_valid & char_ready.
- clr_req while busy sets clear-pending. Clear always has priority over a character arriving in the same cycle. Clear issues 0x01, then DELAY, then col=0, row=0.
- Character (not 0x0A): issue rs=1 with the byte. On ctl_done, col+1. If col reaches COLS: col=0, row toggles (row 1 wraps to 0), then issue rs=0 command 0x80|(row?0x40:0x00) before returning to IDLE.
- Newline 0x0A: no data write. col=0, row toggles, issue the set-address command.
- Strobe rate: at most one ctl_strobe per controller transaction. A new strobe never occurs before the done of the previous one.
- Latency: accept to ctl_strobe = 1 cycle. ctl_done to char_ready = 1 cycle, or 1 cycle after the address command completes.

Optional Feature:
LCD_SEQ_TIMEOUT_EN: when defined, a counter runs in WAIT. If it reaches TIMEOUT_CYCLES without ctl_done: err=1 (sticky), init_done=0, col/row=0, restart the init list from index 0 (no PWRUP wait). When undefined: WAIT waits indefinitely, err is tied to 0, and no counter is synthesised.

Test Plan:
1. Power-up (POWERUP_CYCLES=100, controller model answering done 5 cycles after strobe) -> no strobe for 100 cycles; strobes carry 0x28, 0x06, 0x0C, 0x01 (rs=0); init_done=1 after CLEAR_WAIT_CYCLES; char_ready=0 until then.
2. Send 'A' (0x41) -> one strobe with rs=1 data=0x41; cursor_col 0->1; char_ready returns 1 cycle after done.
3. COLS=16, send 16 characters -> 16th is followed by command 0xC0 (rs=0); col=0, row=1. 16 more -> command 0x80, row=0.
4. Send 0x0A at col 5 row 0 -> no data write; single command 0xC0; col=0, row=1.
5. clr_req pulse during a character WAIT, plus char_valid held -> character completes, then 0x01 issues before any new char; char_ready stays 0 through DELAY; col=row=0.
6. LCD_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50, model withholds done -> err=1 at cycle 50 of WAIT; init_done=0; next strobe carries 0x28. Assert rst=0 mid-sequence -> all outputs at reset values immediately.

Source files
------------

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: HD44780 init list, character stream and cursor tracking
// in front of lcd_controller. Optional done watchdog: LCD_SEQ_TIMEOUT_EN.
module lcd_sequencer #(
    parameter int CLK_PERIOD_NS     = 20,
    parameter int POWERUP_CYCLES    = 750000,
    parameter int CLEAR_WAIT_CYCLES = 82000,
    parameter int COLS              = 16,
    parameter int TIMEOUT_CYCLES    = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    input  logic       clr_req,
    output logic       ctl_rs,
    output logic [7:0] ctl_data,
    output logic       ctl_strobe,
    output logic [7:0] ctl_period_clk_ns,
    input  logic       ctl_done,
    output logic       init_done,
    output logic [3:0] cursor_col,
    output logic       cursor_row,
    output logic       err
);

    localparam int CMAX = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ?
                          POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PW_LAST = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] CL_LAST = CW'(CLEAR_WAIT_CYCLES - 1);
    localparam logic [3:0] COL_LAST = 4'(COLS - 1);

    if (COLS < 2 || COLS > 16 || CLK_PERIOD_NS > 255 ||
        CLK_PERIOD_NS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("lcd_sequencer: illegal parameter value");
    end

    typedef enum logic [2:0] {PWRUP, ISSUE, WAIT, DELAY, IDLE} state_t;
    typedef enum logic [1:0] {K_INIT, K_CHAR, K_ADDR, K_CLR} kind_t;

    state_t        state;
    kind_t         kind;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          clr_pend;
    logic [3:0]    col;
    logic          row;

`ifdef LCD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt;
`else
    assign err = 1'b0;
`endif

    function automatic logic [7:0] init_word(input logic [1:0] i);
        unique case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    assign ctl_period_clk_ns = 8'(CLK_PERIOD_NS);
    assign cursor_col = col;
    assign cursor_row = row;
    assign char_ready = (state == IDLE) & init_done & ~clr_pend & ~clr_req;

    logic       is_clr;
    logic       adv;
    logic       adv_issue;
    logic       adv_rs;
    logic [7:0] adv_data;
    kind_t      adv_kind;
    logic [1:0] adv_idx;
    logic [3:0] adv_col;
    logic       adv_row;
    logic       adv_init;

    assign is_clr = ~ctl_rs & (ctl_data == 8'h01);
    assign adv = (state == WAIT && ctl_done && !is_clr) ||
                 (state == DELAY && cnt == CL_LAST);

    // What follows a completed word: next init entry, wrap address, or idle
    always_comb begin
        adv_issue = 1'b0;
        adv_rs    = 1'b0;
        adv_data  = 8'h00;
        adv_kind  = kind;
        adv_idx   = idx;
        adv_col   = col;
        adv_row   = row;
        adv_init  = init_done;
        unique case (kind)
            K_INIT: begin
                if (idx == 2'd3) begin
                    adv_init = 1'b1;
                    adv_col  = 4'd0;
                    adv_row  = 1'b0;
                end else begin
                    adv_issue = 1'b1;
                    adv_idx   = idx + 2'd1;
                    adv_data  = init_word(idx + 2'd1);
                end
            end
            K_CHAR: begin
                if (col == COL_LAST) begin
                    adv_col   = 4'd0;
                    adv_row   = ~row;
                    adv_issue = 1'b1;
                    adv_kind  = K_ADDR;
                    adv_data  = {1'b1, ~row, 6'd0};
                end else begin
                    adv_col = col + 4'd1;
                end
            end
            K_ADDR: begin
            end
            K_CLR: begin
                adv_col = 4'd0;
                adv_row = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered controller outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PWRUP;
            kind       <= K_INIT;
            cnt        <= '0;
            idx        <= 2'd0;
            clr_pend   <= 1'b0;
            col        <= 4'd0;
            row        <= 1'b0;
            ctl_rs     <= 1'b0;
            ctl_data   <= 8'h00;
            ctl_strobe <= 1'b0;
            init_done  <= 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
            tcnt       <= '0;
            err        <= 1'b0;
`endif
        end else begin
            ctl_strobe <= 1'b0;
            if (clr_req && state != IDLE) clr_pend <= 1'b1;
            unique case (state)
                PWRUP: begin
                    if (cnt == PW_LAST) begin
                        cnt        <= '0;
                        kind       <= K_INIT;
                        idx        <= 2'd0;
                        ctl_rs     <= 1'b0;
                        ctl_data   <= 8'h28;
                        ctl_strobe <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (ctl_done) begin
`ifdef LCD_SEQ_TIMEOUT_EN
                        tcnt <= '0;
`endif
                        if (is_clr) begin
                            cnt   <= '0;
                            state <= DELAY;
                        end
                    end
`ifdef LCD_SEQ_TIMEOUT_EN
                    else if (tcnt == TO_LAST) begin
                        tcnt       <= '0;
                        err        <= 1'b1;
                        init_done  <= 1'b0;
                        col        <= 4'd0;
                        row        <= 1'b0;
                        kind       <= K_INIT;
                        idx        <= 2'd0;
                        ctl_rs     <= 1'b0;
                        ctl_data   <= 8'h28;
                        ctl_strobe <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                DELAY: begin
                    if (cnt == CL_LAST) cnt <= '0;
                    else cnt <= cnt + CW'(1);
                end
                IDLE: begin
                    if (clr_req || clr_pend) begin
                        clr_pend   <= 1'b0;
                        kind       <= K_CLR;
                        ctl_rs     <= 1'b0;
                        ctl_data   <= 8'h01;
                        ctl_strobe <= 1'b1;
                        state      <= ISSUE;
                    end else if (char_valid && char_ready) begin
                        if (char_data == 8'h0A) begin
                            col      <= 4'd0;
                            row      <= ~row;
                            kind     <= K_ADDR;
                            ctl_rs   <= 1'b0;
                            ctl_data <= {1'b1, ~row, 6'd0};
                        end else begin
                            kind     <= K_CHAR;
                            ctl_rs   <= 1'b1;
                            ctl_data <= char_data;
                        end
                        ctl_strobe <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                default: state <= PWRUP;
            endcase
            if (adv) begin
                kind      <= adv_kind;
                idx       <= adv_idx;
                col       <= adv_col;
                row       <= adv_row;
                init_done <= adv_init;
                if (adv_issue) begin
                    ctl_rs     <= adv_rs;
                    ctl_data   <= adv_data;
                    ctl_strobe <= 1'b1;
                    state      <= ISSUE;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: expected-write queue model of the sequencer plus a
// controller model that answers done a fixed time after each strobe.
module tb_lcd_sequencer;

    localparam int PWR      = 100;
    localparam int CLRW     = 30;
    localparam int NCOLS    = 16;
    localparam int TO       = 50;
    localparam int DONE_LAT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready;
    logic       clr_req = 1'b0;
    logic       ctl_rs;
    logic [7:0] ctl_data;
    logic       ctl_strobe;
    logic [7:0] ctl_period_clk_ns;
    logic       ctl_done = 1'b0;
    logic       init_done;
    logic [3:0] cursor_col;
    logic       cursor_row;
    logic       err;

    lcd_sequencer #(
        .CLK_PERIOD_NS(20),
        .POWERUP_CYCLES(PWR),
        .CLEAR_WAIT_CYCLES(CLRW),
        .COLS(NCOLS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .char_valid(char_valid),
        .char_data(char_data),
        .char_ready(char_ready),
        .clr_req(clr_req),
        .ctl_rs(ctl_rs),
        .ctl_data(ctl_data),
        .ctl_strobe(ctl_strobe),
        .ctl_period_clk_ns(ctl_period_clk_ns),
        .ctl_done(ctl_done),
        .init_done(init_done),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rs;
        logic [7:0] d;
    } wr_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    wr_t  exp_q[$];
    int   req_q[$];
    wr_t  cur;
    int   m_col;
    bit   m_row;
    bit   outst;
    int   cd;
    int   hold;
    int   init_left;
    bit   init_flag;
    bit   need_init;
    bit   first_pending;
    bit   exp_ready;
    bit   err_seen;
    bit   withhold = 1'b0;
    int   edges;
    int   data_edge;
    int   n_data = 0;
    logic [7:0] last_cmd = 8'h00;
    int   r;

    function automatic void check(string nm, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endfunction

    function automatic void push_wr(bit rs, logic [7:0] d);
        wr_t w;
        w.rs = rs;
        w.d  = d;
        exp_q.push_back(w);
    endfunction

    function automatic void model_init();
        push_wr(1'b0, 8'h28);
        push_wr(1'b0, 8'h06);
        push_wr(1'b0, 8'h0C);
        push_wr(1'b0, 8'h01);
        init_left = 4;
        init_flag = 1'b0;
        m_col = 0;
        m_row = 1'b0;
    endfunction

    function automatic void model_char(int b);
        if (b == 10) begin
            m_col = 0;
            m_row = ~m_row;
            push_wr(1'b0, m_row ? 8'hC0 : 8'h80);
        end else begin
            push_wr(1'b1, 8'(b));
            m_col++;
            if (m_col == NCOLS) begin
                m_col = 0;
                m_row = ~m_row;
                push_wr(1'b0, m_row ? 8'hC0 : 8'h80);
            end
        end
    endfunction

    function automatic void model_clear();
        push_wr(1'b0, 8'h01);
        m_col = 0;
        m_row = 1'b0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else edges <= edges + 1;
    end

    // Compare process and controller model, both on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_strobe", ctl_strobe, 0);
            check("rst_rs", ctl_rs, 0);
            check("rst_data", ctl_data, 0);
            check("rst_ready", char_ready, 0);
            check("rst_init_done", init_done, 0);
            check("rst_col", cursor_col, 0);
            check("rst_row", cursor_row, 0);
            check("rst_err", err, 0);
            exp_q.delete();
            req_q.delete();
            outst = 1'b0;
            cd = 0;
            hold = 0;
            ctl_done = 1'b0;
            init_flag = 1'b0;
            need_init = 1'b1;
            first_pending = 1'b1;
            err_seen = 1'b0;
        end else begin
            if (need_init) begin
                model_init();
                need_init = 1'b0;
            end
            while (req_q.size() > 0) begin
                r = req_q.pop_front();
                if (r == 256) model_clear();
                else model_char(r);
            end
            if (init_left == 0 && hold == 0) init_flag = 1'b1;
`ifdef LCD_SEQ_TIMEOUT_EN
            if (err && !err_seen) begin
                err_seen = 1'b1;
                outst = 1'b0;
                cd = 0;
                exp_q.delete();
                model_init();
            end
`endif
            check("err", err, int'(err_seen));
            ctl_done = 1'b0;
            exp_ready = init_flag && exp_q.size() == 0 && !outst &&
                        hold == 0 && !clr_req;
            check("char_ready", char_ready, int'(exp_ready));
            check("init_done", init_done, int'(init_flag));
            if (exp_ready) begin
                check("cursor_col", cursor_col, m_col);
                check("cursor_row", cursor_row, int'(m_row));
            end
            if (hold > 0) hold--;
            if (ctl_strobe) begin
                check("strobe_overlap", int'(outst), 0);
                check("strobe_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    check("wr_rs", ctl_rs, int'(cur.rs));
                    check("wr_data", ctl_data, cur.d);
                end
                if (first_pending) begin
                    check("powerup_cycles", edges, PWR);
                    first_pending = 1'b0;
                end
                if (ctl_rs) begin
                    n_data++;
                    data_edge = edges;
                end else begin
                    last_cmd = ctl_data;
                end
                outst = 1'b1;
                cd = DONE_LAT;
            end else if (outst) begin
                check("hold_rs", ctl_rs, int'(cur.rs));
                check("hold_data", ctl_data, cur.d);
                if (cd > 0) cd--;
                if (cd == 0 && !withhold) begin
                    ctl_done = 1'b1;
                    outst = 1'b0;
                    if (init_left > 0) init_left--;
                    if (!cur.rs && cur.d == 8'h01) hold = CLRW;
                end
            end
        end
    end

    task automatic wait_ready(input int maxc, input string nm);
        int k;
        k = 0;
        while (k < maxc) begin
            @(negedge clk);
            if (char_ready) break;
            k++;
        end
        check(nm, char_ready, 1);
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        char_valid = 1'b1;
        char_data = b;
        wait_ready(2000, "accept");
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        req_q.push_back(int'(b));
        @(negedge clk);
        check("accept_to_strobe", ctl_strobe, 1);
        wait_ready(2000, "done_to_ready");
    endtask

    initial begin
        int nd;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check("period", ctl_period_clk_ns, 20);

        // power-up and init list
        wait_ready(1000, "init_ready");
        check("init_done_lit", init_done, 1);
        check("init_last_cmd", last_cmd, 8'h01);

        // single character
        send(8'h41);
        check("a_col", cursor_col, 1);
        check("a_row", cursor_row, 0);

        // wrap to row 1, then back to row 0
        for (int i = 0; i < 15; i++) send(8'(8'h42 + i));
        check("wrap1_col", cursor_col, 0);
        check("wrap1_row", cursor_row, 1);
        check("wrap1_cmd", last_cmd, 8'hC0);
        for (int i = 0; i < 16; i++) send(8'(8'h61 + i));
        check("wrap2_col", cursor_col, 0);
        check("wrap2_row", cursor_row, 0);
        check("wrap2_cmd", last_cmd, 8'h80);

        // newline at column 5
        for (int i = 0; i < 5; i++) send(8'(8'h30 + i));
        check("nl_pre_col", cursor_col, 5);
        nd = n_data;
        send(8'h0A);
        check("nl_no_data", n_data, nd);
        check("nl_col", cursor_col, 0);
        check("nl_row", cursor_row, 1);
        check("nl_cmd", last_cmd, 8'hC0);

        // clear during a character, with the next character waiting
        @(posedge clk);
        #1;
        char_valid = 1'b1;
        char_data = 8'h42;
        wait_ready(100, "accept_b");
        @(posedge clk);
        #1;
        req_q.push_back(8'h42);
        char_data = 8'h43;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        clr_req = 1'b1;
        req_q.push_back(256);
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        wait_ready(500, "accept_c");
        check("clr_cmd", last_cmd, 8'h01);
        check("clr_col", cursor_col, 0);
        check("clr_row", cursor_row, 0);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        req_q.push_back(8'h43);
        @(negedge clk);
        check("c_strobe", ctl_strobe, 1);
        wait_ready(100, "c_ready");
        check("c_col", cursor_col, 1);

`ifdef LCD_SEQ_TIMEOUT_EN
        // withheld done triggers the watchdog and a fresh init list
        withhold = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b1;
        char_data = 8'h58;
        wait_ready(100, "accept_x");
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        req_q.push_back(8'h58);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (err) break;
        end
        check("to_err", err, 1);
        check("to_cycles", edges - data_edge, TO);
        check("to_init_done", init_done, 0);
        check("to_cmd", last_cmd, 8'h28);
        @(posedge clk);
        #1;
        withhold = 1'b0;
        wait_ready(1000, "to_reinit");
        check("to_err_sticky", err, 1);
        check("to_col", cursor_col, 0);
`endif

        // reset in the middle of a transfer
        @(posedge clk);
        #1;
        char_valid = 1'b1;
        char_data = 8'h5A;
        wait_ready(100, "accept_z");
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        req_q.push_back(8'h5A);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_strobe", ctl_strobe, 0);
        check("mid_rst_data", ctl_data, 0);
        check("mid_rst_init", init_done, 0);
        check("mid_rst_col", cursor_col, 0);
        check("mid_rst_ready", char_ready, 0);
        check("mid_rst_err", err, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_ready(1000, "reinit_ready");
        check("reinit_row", cursor_row, 0);
        send(8'h51);
        check("q_col", cursor_col, 1);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
